score_keeper_bcd: RTL and testbench

//   Parametrised game score keeper. Counts edge-detected good collisions,

---
 rtl/score_keeper_bcd.sv | 197 +++++++++++++++++++
 tb/tb_score_keeper_bcd.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper_bcd.sv
// score_keeper_bcd
//   Game score keeper placed between the collision detector and the score
//   renderer. Good collisions are edge-detected and add POINTS (saturating
//   at MAX_SCORE). A bad collision, or reaching MAX_SCORE, ends the game.
//   A session high score survives restarts. The displayed value is the
//   current score while playing and the high score once the game is over.
//   It is converted to BCD by a one-bit-per-clock double-dabble.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-high
//   good_coll      good collision level (may be held for many cycles)
//   bad_coll       bad collision level
//   start          one-cycle request for a new game (only acted on when over)
//   current_score  score of the game in progress
//   high_score     best score since reset
//   disp_score     current_score while playing, high_score when game over
//   bcd            BCD of disp_score; digit 0 (ones) in bcd[3:0]
//   bcd_valid      bcd matches disp_score
//   game_over      game has ended
//   game_won       last game ended by reaching MAX_SCORE
module score_keeper_bcd #(
   parameter int SCORE_W   = 7,
   parameter int MAX_SCORE = 50,
   parameter int POINTS    = 1,
   parameter int DIGITS    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  good_coll,
   input  logic                  bad_coll,
   input  logic                  start,
   output logic [SCORE_W-1:0]    current_score,
   output logic [SCORE_W-1:0]    high_score,
   output logic [SCORE_W-1:0]    disp_score,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   output logic                  game_over,
   output logic                  game_won
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(SCORE_W + 1);
   localparam logic [SCORE_W:0]  MAX_EXT  = (SCORE_W + 1)'(MAX_SCORE);
   localparam logic [SCORE_W:0]  PTS_EXT  = (SCORE_W + 1)'(POINTS);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SCORE_W - 1);

   typedef enum logic {PLAYING = 1'b0, GAME_OVER = 1'b1} game_state_t;
   typedef enum logic {C_IDLE = 1'b0, C_SHIFT = 1'b1} conv_state_t;

   // ---------------------------------------------------------------- game
   game_state_t         state_reg, state_next;
   logic [SCORE_W-1:0]  score_reg, score_next;
   logic [SCORE_W-1:0]  high_reg, high_next;
   logic [SCORE_W-1:0]  disp_reg, disp_next;
   logic                won_reg, won_next;
   logic                good_q_reg;
   logic                hit;
   logic [SCORE_W:0]    sum_ext, capped_ext;

   assign hit = good_coll & ~good_q_reg;

   // One extra bit so the addition can never wrap before saturation.
   assign sum_ext    = {1'b0, score_reg} + PTS_EXT;
   assign capped_ext = (sum_ext >= MAX_EXT) ? MAX_EXT : sum_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= PLAYING;
         score_reg  <= '0;
         high_reg   <= '0;
         disp_reg   <= '0;
         won_reg    <= 1'b0;
         good_q_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         score_reg  <= score_next;
         high_reg   <= high_next;
         disp_reg   <= disp_next;
         won_reg    <= won_next;
         good_q_reg <= good_coll;
      end
   end

   always_comb begin
      state_next = state_reg;
      score_next = score_reg;
      high_next  = high_reg;
      won_next   = won_reg;
      case (state_reg)
         PLAYING: begin
            // A bad collision wins over a simultaneous hit.
            if (bad_coll) begin
               state_next = GAME_OVER;
               won_next   = 1'b0;
            end else if (hit) begin
               score_next = capped_ext[SCORE_W-1:0];
               if (capped_ext == MAX_EXT) begin
                  state_next = GAME_OVER;
                  won_next   = 1'b1;
               end
            end
            if (score_next > high_reg)
               high_next = score_next;
         end
         GAME_OVER: begin
            if (start) begin
               state_next = PLAYING;
               score_next = '0;
               won_next   = 1'b0;
            end
         end
      endcase
      // Display register tracks the post-update state and scores.
      disp_next = (state_next == GAME_OVER) ? high_next : score_next;
   end

   // ------------------------------------------------------- BCD converter
   conv_state_t         conv_reg, conv_next;
   logic [SCORE_W-1:0]  src_reg, src_next;
   logic [SCORE_W-1:0]  bin_reg, bin_next;
   logic [BCD_W-1:0]    scratch_reg, scratch_next;
   logic [BCD_W-1:0]    bcd_reg, bcd_next;
   logic [BCD_W-1:0]    adj;
   logic [BCD_W-1:0]    shifted;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic                valid_reg, valid_next;

   // Add 3 to every digit that would overflow past 9 after the shift.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                 ? scratch_reg[4*gi +: 4] + 4'd3
                                 : scratch_reg[4*gi +: 4];
      end
   endgenerate

   assign shifted = {adj[BCD_W-2:0], bin_reg[SCORE_W-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_reg    <= C_IDLE;
         src_reg     <= '0;
         bin_reg     <= '0;
         scratch_reg <= '0;
         bcd_reg     <= '0;
         count_reg   <= '0;
         valid_reg   <= 1'b1;
      end else begin
         conv_reg    <= conv_next;
         src_reg     <= src_next;
         bin_reg     <= bin_next;
         scratch_reg <= scratch_next;
         bcd_reg     <= bcd_next;
         count_reg   <= count_next;
         valid_reg   <= valid_next;
      end
   end

   always_comb begin
      conv_next    = conv_reg;
      src_next     = src_reg;
      bin_next     = bin_reg;
      scratch_next = scratch_reg;
      bcd_next     = bcd_reg;
      count_next   = count_reg;
      valid_next   = valid_reg;
      // A changed source (idle or mid-shift) always (re)starts a conversion;
      // bcd itself is only written when a full pass completes.
      if (disp_reg != src_reg) begin
         conv_next    = C_SHIFT;
         src_next     = disp_reg;
         bin_next     = disp_reg;
         scratch_next = '0;
         count_next   = '0;
         valid_next   = 1'b0;
      end else if (conv_reg == C_SHIFT) begin
         scratch_next = shifted;
         bin_next     = bin_reg << 1;
         count_next   = count_reg + 1'b1;
         if (count_reg == LAST_CNT) begin
            bcd_next   = shifted;
            valid_next = 1'b1;
            conv_next  = C_IDLE;
         end
      end
   end

   assign current_score = score_reg;
   assign high_score    = high_reg;
   assign disp_score    = disp_reg;
   assign bcd           = bcd_reg;
   assign bcd_valid     = valid_reg;
   assign game_over     = (state_reg == GAME_OVER);
   assign game_won      = won_reg;

endmodule

// File: tb/tb_score_keeper_bcd.sv
module tb_score_keeper_bcd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       good_coll = 1'b0;
   logic       bad_coll = 1'b0;
   logic       start = 1'b0;
   logic [6:0] current_score;
   logic [6:0] high_score;
   logic [6:0] disp_score;
   logic [7:0] bcd;
   logic       bcd_valid;
   logic       game_over;
   logic       game_won;

   int checks = 0;
   int errors = 0;

   score_keeper_bcd #(
      .SCORE_W(7), .MAX_SCORE(50), .POINTS(1), .DIGITS(2)
   ) dut (
      .clk(clk), .rst(rst), .good_coll(good_coll), .bad_coll(bad_coll),
      .start(start), .current_score(current_score), .high_score(high_score),
      .disp_score(disp_score), .bcd(bcd), .bcd_valid(bcd_valid),
      .game_over(game_over), .game_won(game_won)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Stimulus helpers (called at a negedge, return at a negedge).
   task automatic do_reset();
      rst = 1'b1; good_coll = 1'b0; bad_coll = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_good(input int hi, input int lo);
      good_coll = 1'b1;
      repeat (hi) @(negedge clk);
      good_coll = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic pulse_bad();
      bad_coll = 1'b1;
      @(negedge clk);
      bad_coll = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 6;
      if (current_score !== 7'd0) begin errors++; $display("FAIL reset_cur got %0d required 0", current_score); end
      if (high_score !== 7'd0) begin errors++; $display("FAIL reset_high got %0d required 0", high_score); end
      if (disp_score !== 7'd0) begin errors++; $display("FAIL reset_disp got %0d required 0", disp_score); end
      if (bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd got %h required 00", bcd); end
      if (bcd_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b required 1", bcd_valid); end
      if ({game_over, game_won} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b required 00", {game_over, game_won}); end
      $display("test_reset done");
   endtask

   task automatic test_held_pulses();
      do_reset();
      pulse_good(4, 2);
      checks++;
      if (current_score !== 7'd1) begin errors++; $display("FAIL held_once got %0d required 1", current_score); end
      pulse_good(4, 2);
      pulse_good(4, 2);
      checks += 3;
      if (current_score !== 7'd3) begin errors++; $display("FAIL held_cur got %0d required 3", current_score); end
      if (high_score !== 7'd3) begin errors++; $display("FAIL held_high got %0d required 3", high_score); end
      if (disp_score !== 7'd3) begin errors++; $display("FAIL held_disp got %0d required 3", disp_score); end
      repeat (9) @(negedge clk);
      checks++;
      if ({bcd_valid, bcd} !== {1'b1, 8'h03}) begin errors++; $display("FAIL held_bcd got %b/%h required 1/03", bcd_valid, bcd); end
      $display("test_held_pulses done");
   endtask

   task automatic test_bad_with_good();
      do_reset();
      repeat (12) pulse_good(1, 1);
      good_coll = 1'b1; bad_coll = 1'b1;
      @(negedge clk);
      good_coll = 1'b0; bad_coll = 1'b0;
      checks += 4;
      if (game_over !== 1'b1) begin errors++; $display("FAIL badgood_over got %b required 1", game_over); end
      if (current_score !== 7'd12) begin errors++; $display("FAIL badgood_cur got %0d required 12", current_score); end
      if (game_won !== 1'b0) begin errors++; $display("FAIL badgood_won got %b required 0", game_won); end
      if (disp_score !== 7'd12) begin errors++; $display("FAIL badgood_disp got %0d required 12", disp_score); end
      // Collisions while over must be ignored.
      pulse_good(1, 1);
      repeat (10) @(negedge clk);
      checks += 2;
      if (current_score !== 7'd12) begin errors++; $display("FAIL over_ignore got %0d required 12", current_score); end
      if ({bcd_valid, bcd} !== {1'b1, 8'h12}) begin errors++; $display("FAIL badgood_bcd got %b/%h required 1/12", bcd_valid, bcd); end
      $display("test_bad_with_good done");
   endtask

   task automatic test_max_score();
      do_reset();
      repeat (49) pulse_good(1, 1);
      checks += 2;
      if (current_score !== 7'd49) begin errors++; $display("FAIL max_49 got %0d required 49", current_score); end
      if (game_over !== 1'b0) begin errors++; $display("FAIL max_49_over got %b required 0", game_over); end
      pulse_good(1, 1);
      checks += 3;
      if (current_score !== 7'd50) begin errors++; $display("FAIL max_50 got %0d required 50", current_score); end
      if ({game_over, game_won} !== 2'b11) begin errors++; $display("FAIL max_flags got %b required 11", {game_over, game_won}); end
      if (high_score !== 7'd50) begin errors++; $display("FAIL max_high got %0d required 50", high_score); end
      pulse_good(1, 1);
      repeat (10) @(negedge clk);
      checks += 2;
      if (current_score !== 7'd50) begin errors++; $display("FAIL max_51 got %0d required 50", current_score); end
      if ({bcd_valid, bcd} !== {1'b1, 8'h50}) begin errors++; $display("FAIL max_bcd got %b/%h required 1/50", bcd_valid, bcd); end
      $display("test_max_score done");
   endtask

   task automatic test_high_score();
      do_reset();
      repeat (23) pulse_good(1, 1);
      pulse_bad();
      checks++;
      if ({game_over, current_score} !== {1'b1, 7'd23}) begin errors++; $display("FAIL hs_game1 got %b/%0d required 1/23", game_over, current_score); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks += 4;
      if (game_over !== 1'b0) begin errors++; $display("FAIL hs_start_over got %b required 0", game_over); end
      if (current_score !== 7'd0) begin errors++; $display("FAIL hs_start_cur got %0d required 0", current_score); end
      if (disp_score !== 7'd0) begin errors++; $display("FAIL hs_start_disp got %0d required 0", disp_score); end
      if (high_score !== 7'd23) begin errors++; $display("FAIL hs_start_high got %0d required 23", high_score); end
      repeat (9) pulse_good(1, 1);
      pulse_bad();
      checks += 3;
      if (current_score !== 7'd9) begin errors++; $display("FAIL hs_game2 got %0d required 9", current_score); end
      if (high_score !== 7'd23) begin errors++; $display("FAIL hs_high got %0d required 23", high_score); end
      if (disp_score !== 7'd23) begin errors++; $display("FAIL hs_disp got %0d required 23", disp_score); end
      repeat (10) @(negedge clk);
      checks++;
      if ({bcd_valid, bcd} !== {1'b1, 8'h23}) begin errors++; $display("FAIL hs_bcd got %b/%h required 1/23", bcd_valid, bcd); end
      $display("test_high_score done");
   endtask

   task automatic test_restart_conversion();
      do_reset();
      repeat (9) pulse_good(1, 1);
      repeat (10) @(negedge clk);
      checks++;
      if ({bcd_valid, bcd} !== {1'b1, 8'h09}) begin errors++; $display("FAIL rc_pre got %b/%h required 1/09", bcd_valid, bcd); end
      // First change at edge E0 (score 10).
      good_coll = 1'b1;
      @(negedge clk);
      good_coll = 1'b0;
      checks++;
      if ({bcd_valid, disp_score} !== {1'b1, 7'd10}) begin errors++; $display("FAIL rc_e0 got %b/%0d required 1/10", bcd_valid, disp_score); end
      @(negedge clk);
      checks++;
      if ({bcd_valid, bcd} !== {1'b0, 8'h09}) begin errors++; $display("FAIL rc_e1 got %b/%h required 0/09", bcd_valid, bcd); end
      @(negedge clk);
      // Second change at edge E3 (score 11).
      good_coll = 1'b1;
      @(negedge clk);
      good_coll = 1'b0;
      checks++;
      if ({bcd_valid, bcd, disp_score} !== {1'b0, 8'h09, 7'd11}) begin errors++; $display("FAIL rc_e3 got %b/%h/%0d required 0/09/11", bcd_valid, bcd, disp_score); end
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         checks++;
         if ({bcd_valid, bcd} !== {1'b0, 8'h09}) begin errors++; $display("FAIL rc_busy%0d got %b/%h required 0/09", i, bcd_valid, bcd); end
      end
      @(negedge clk);
      checks++;
      if ({bcd_valid, bcd} !== {1'b1, 8'h11}) begin errors++; $display("FAIL rc_final got %b/%h required 1/11", bcd_valid, bcd); end
      $display("test_restart_conversion done");
   endtask

   task automatic test_reset_mid_conversion();
      do_reset();
      repeat (37) pulse_good(1, 1);
      checks++;
      if ({bcd_valid, current_score} !== {1'b0, 7'd37}) begin errors++; $display("FAIL rm_pre got %b/%0d required 0/37", bcd_valid, current_score); end
      #2 rst = 1'b1;
      #1;
      checks += 3;
      if ({current_score, high_score, disp_score} !== 21'd0) begin errors++; $display("FAIL rm_scores got %0d/%0d/%0d required 0/0/0", current_score, high_score, disp_score); end
      if ({bcd_valid, bcd} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rm_bcd got %b/%h required 1/00", bcd_valid, bcd); end
      if ({game_over, game_won} !== 2'b00) begin errors++; $display("FAIL rm_flags got %b required 00", {game_over, game_won}); end
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if ({bcd_valid, bcd, current_score} !== {1'b1, 8'h00, 7'd0}) begin errors++; $display("FAIL rm_after got %b/%h/%0d required 1/00/0", bcd_valid, bcd, current_score); end
      $display("test_reset_mid_conversion done");
   endtask

   initial begin
      test_reset();
      test_held_pulses();
      test_bad_with_good();
      test_max_score();
      test_high_score();
      test_restart_conversion();
      test_reset_mid_conversion();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
